// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, UART framing and dump state encoding
// Contents: FB_COLUMNS, FB_BYTES_PER_COLUMN, UART_FRAME_BITS, fb_state_t, bit_reverse().
package fb_pkg;

    localparam int FB_COLUMNS          = 240;
    localparam int FB_BYTES_PER_COLUMN = 8;
    localparam int UART_FRAME_BITS     = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP
    } fb_state_t;

    // The receive path stores bytes mirrored, so the dump mirrors them back.
    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte serializer with a one-byte holding register
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   baud_x1      : one-clk strobe per bit period; the line only changes on it
//   data, load   : byte to send, accepted when load and ready are both high
//   serial       : TX line, idles high
//   ready        : holding register empty and the line is idle or in its stop bit
module uart_tx_byte
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_x1,
    input  logic [7:0] data,
    input  logic       load,
    output logic       serial,
    output logic       ready
);

    localparam int DATA_BITS = UART_FRAME_BITS - 2;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    fb_state_t  state;
    logic [7:0] shift;
    logic [7:0] hold;
    logic       pending;
    logic [2:0] bit_cnt;

    // Accepting a byte during the stop bit lets the next start bit follow
    // on the strobe that ends the stop bit, with no idle gap.
    assign ready = !pending && (state == ST_IDLE || state == ST_STOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shift   <= 8'h00;
            hold    <= 8'h00;
            pending <= 1'b0;
            bit_cnt <= 3'd0;
            serial  <= 1'b1;
        end else begin
            // ready implies !pending, and the holding register is only drained
            // when pending is set, so these two never collide.
            if (load && ready) begin
                hold    <= data;
                pending <= 1'b1;
            end
            if (baud_x1) begin
                case (state)
                    ST_IDLE, ST_STOP: begin
                        if (pending) begin
                            serial  <= 1'b0;
                            shift   <= hold;
                            pending <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            serial <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        serial  <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= 3'd0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            serial <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            serial  <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/fb_uart_dump.sv
// rtl/fb_uart_dump.sv - streams the LCD framebuffer out over UART, column-major, bytes mirrored
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   baud_x1      : one-clk bit-rate strobe (period must be >= 4 clk)
//   start        : one-cycle dump request, ignored while busy
//   fb_x, fb_y   : framebuffer read address (column, byte within column)
//   fb_byte      : registered read data, valid one clk after the address
//   serial       : UART TX line
//   busy, done   : dump in progress / one-cycle pulse after the last stop bit
module fb_uart_dump
    import fb_pkg::*;
#(
    parameter int COLUMNS          = FB_COLUMNS,
    parameter int BYTES_PER_COLUMN = FB_BYTES_PER_COLUMN
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_x1,
    input  logic       start,
    output logic [7:0] fb_x,
    output logic [2:0] fb_y,
    input  logic [7:0] fb_byte,
    output logic       serial,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] LAST_X = 8'(COLUMNS - 1);
    localparam logic [2:0] LAST_Y = 3'(BYTES_PER_COLUMN - 1);

    // ST_DATA: a byte is on the wire, waiting for its stop bit so the next
    //          byte can be prefetched.
    // ST_STOP: the final byte's stop bit; the next strobe ends the dump.
    fb_state_t  state;
    logic       tx_ready;
    logic       tx_load;
    logic [7:0] tx_data;
    logic       last_byte;

    assign tx_load   = (state == ST_LOAD);
    assign tx_data   = bit_reverse(fb_byte);
    assign last_byte = (fb_x == LAST_X) && (fb_y == LAST_Y);

    uart_tx_byte u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .baud_x1 (baud_x1),
        .data    (tx_data),
        .load    (tx_load),
        .serial  (serial),
        .ready   (tx_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            fb_x  <= 8'd0;
            fb_y  <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        fb_x  <= 8'd0;
                        fb_y  <= 3'd0;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                // Address is stable here; the framebuffer registers it at the end.
                ST_FETCH: state <= ST_LOAD;
                // The serializer is ready in this cycle: either idle (first byte)
                // or sitting in a stop bit with an empty holding register.
                ST_LOAD:  state <= ST_DATA;
                ST_DATA: begin
                    if (tx_ready) begin
                        if (last_byte) begin
                            state <= ST_STOP;
                        end else begin
                            if (fb_y == LAST_Y) begin
                                fb_y <= 3'd0;
                                fb_x <= fb_x + 8'd1;
                            end else begin
                                fb_y <= fb_y + 3'd1;
                            end
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_STOP: begin
                    if (baud_x1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        fb_x  <= 8'd0;
                        fb_y  <= 3'd0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
